// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Purpose  : Packs register fields and a 32-bit immediate into an RV32I word,
//            flagging immediates that would not survive sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module imm_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 inValid,
    output logic                 inReady,
    input  logic [2:0]           immSrc,
    input  logic [31:0]          immValue,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,

    output logic                 outValid,
    input  logic                 outReady,
    output logic [31:0]          instr,
    output logic                 rangeErr,
    output logic [ERR_CNT_W-1:0] errCount
);

    localparam logic [2:0] c_SRC_I = 3'b000;
    localparam logic [2:0] c_SRC_S = 3'b001;
    localparam logic [2:0] c_SRC_B = 3'b010;
    localparam logic [2:0] c_SRC_U = 3'b011;
    localparam logic [2:0] c_SRC_J = 3'b100;

    localparam logic [ERR_CNT_W-1:0] c_ERR_MAX = {ERR_CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Stage A: captured request
    // ------------------------------------------------------------------
    logic        r_valid_a;
    logic [2:0]  r_src_a;
    logic [31:0] r_imm_a;
    logic [6:0]  r_opcode_a;
    logic [4:0]  r_rd_a;
    logic [4:0]  r_rs1_a;
    logic [4:0]  r_rs2_a;
    logic [2:0]  r_f3_a;
    logic [6:0]  r_f7_a;

    // ------------------------------------------------------------------
    // Stage B: output register and error counter
    // ------------------------------------------------------------------
    logic                 r_out_valid;
    logic [31:0]          r_instr;
    logic                 r_range_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic        w_adv_a;
    logic        w_adv_b;
    logic [31:0] w_instr;
    logic        w_range_err;
    logic        w_hi_i_ok;
    logic        w_hi_b_ok;
    logic        w_hi_j_ok;

    assign w_adv_b = !r_out_valid || outReady;
    assign w_adv_a = !r_valid_a || w_adv_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_a  <= 1'b0;
            r_src_a    <= 3'b000;
            r_imm_a    <= 32'd0;
            r_opcode_a <= 7'd0;
            r_rd_a     <= 5'd0;
            r_rs1_a    <= 5'd0;
            r_rs2_a    <= 5'd0;
            r_f3_a     <= 3'd0;
            r_f7_a     <= 7'd0;
        end else if (w_adv_a) begin
            r_valid_a <= inValid;
            if (inValid) begin
                r_src_a    <= immSrc;
                r_imm_a    <= immValue;
                r_opcode_a <= opcode;
                r_rd_a     <= rd;
                r_rs1_a    <= rs1;
                r_rs2_a    <= rs2;
                r_f3_a     <= funct3;
                r_f7_a     <= funct7;
            end
        end
    end

    // The extender sign-fills from the top immediate bit, so every bit above it must match.
    assign w_hi_i_ok = (&r_imm_a[31:11]) || (~|r_imm_a[31:11]);
    assign w_hi_b_ok = (&r_imm_a[31:12]) || (~|r_imm_a[31:12]);
    assign w_hi_j_ok = (&r_imm_a[31:20]) || (~|r_imm_a[31:20]);

    always_comb begin
        w_instr     = 32'd0;
        w_range_err = 1'b0;
        case (r_src_a)
            c_SRC_I: begin
                w_instr     = {r_imm_a[11:0], r_rs1_a, r_f3_a, r_rd_a, r_opcode_a};
                w_range_err = !w_hi_i_ok;
            end
            c_SRC_S: begin
                w_instr     = {r_imm_a[11:5], r_rs2_a, r_rs1_a, r_f3_a,
                               r_imm_a[4:0], r_opcode_a};
                w_range_err = !w_hi_i_ok;
            end
            c_SRC_B: begin
                w_instr     = {r_imm_a[12], r_imm_a[10:5], r_rs2_a, r_rs1_a, r_f3_a,
                               r_imm_a[4:1], r_imm_a[11], r_opcode_a};
                w_range_err = !w_hi_b_ok || r_imm_a[0];
            end
            c_SRC_U: begin
                w_instr     = {r_imm_a[31:12], r_rd_a, r_opcode_a};
                w_range_err = |r_imm_a[11:0];
            end
            c_SRC_J: begin
                w_instr     = {r_imm_a[20], r_imm_a[10:1], r_imm_a[11], r_imm_a[19:12],
                               r_rd_a, r_opcode_a};
                w_range_err = !w_hi_j_ok || r_imm_a[0];
            end
            default: begin
                w_instr     = {r_f7_a, r_rs2_a, r_rs1_a, r_f3_a, r_rd_a, r_opcode_a};
                w_range_err = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_instr     <= 32'd0;
            r_range_err <= 1'b0;
        end else if (w_adv_b) begin
            r_out_valid <= r_valid_a;
            if (r_valid_a) begin
                r_instr     <= w_instr;
                r_range_err <= w_range_err;
            end
        end
    end

    // Counts delivered bad words only, so a stalled word is never counted twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (r_out_valid && outReady && r_range_err && (r_err_count != c_ERR_MAX)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

    assign inReady  = w_adv_a;
    assign outValid = r_out_valid;
    assign instr    = r_instr;
    assign rangeErr = r_range_err;
    assign errCount = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_encoder
// Purpose  : Directed self-checking bench for imm_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [2:0]  immSrc;
    logic [31:0] immValue;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        outValid;
    logic        outReady;
    logic [31:0] instr;
    logic        rangeErr;
    logic [7:0]  errCount;

    int n_cmp = 0;
    int n_err = 0;

    imm_encoder #(.ERR_CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inReady  (inReady),
        .immSrc   (immSrc),
        .immValue (immValue),
        .opcode   (opcode),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .outValid (outValid),
        .outReady (outReady),
        .instr    (instr),
        .rangeErr (rangeErr),
        .errCount (errCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] src, input logic [31:0] imm, input logic [6:0] op,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [2:0] f3, input logic [6:0] f7);
        immSrc   = src;
        immValue = imm;
        opcode   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        funct7   = f7;
    endtask

    // One isolated word with outReady=1: accept, wait one stage, check, drain.
    task automatic one_word(input string tag, input logic [31:0] exp_instr, input logic exp_err);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        tick();
        check({tag, ".valid"}, {31'd0, outValid}, 32'd1);
        check({tag, ".instr"}, instr, exp_instr);
        check({tag, ".err"},   {31'd0, rangeErr}, {31'd0, exp_err});
        tick();
    endtask

    logic [31:0] drained[$];
    int          accepted;
    int          seen;
    logic        acc;

    initial begin
        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        set_in(3'b000, 32'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst.outValid", {31'd0, outValid}, 32'd0);
        check("rst.instr",    instr, 32'd0);
        check("rst.rangeErr", {31'd0, rangeErr}, 32'd0);
        check("rst.errCount", {24'd0, errCount}, 32'd0);
        check("rst.inReady",  {31'd0, inReady}, 32'd1);

        // addi x1,x0,5 with 2-cycle latency
        set_in(3'b000, 32'd5, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        check("addi.lat1", {31'd0, outValid}, 32'd0);
        tick();
        check("addi.lat2",  {31'd0, outValid}, 32'd1);
        check("addi.instr", instr, 32'h00500093);
        check("addi.err",   {31'd0, rangeErr}, 32'd0);
        tick();
        check("addi.gone",  {31'd0, outValid}, 32'd0);

        // sw / lui / jal back to back
        set_in(3'b001, 32'd8, 7'h23, 5'd0, 5'd0, 5'd2, 3'd2, 7'd0);
        inValid = 1'b1;
        tick();
        set_in(3'b011, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0);
        tick();
        check("b2b.sw.valid", {31'd0, outValid}, 32'd1);
        check("b2b.sw",       instr, 32'h00202423);
        check("b2b.sw.err",   {31'd0, rangeErr}, 32'd0);
        set_in(3'b100, 32'd8, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        tick();
        check("b2b.lui.valid", {31'd0, outValid}, 32'd1);
        check("b2b.lui",       instr, 32'h123452B7);
        check("b2b.lui.err",   {31'd0, rangeErr}, 32'd0);
        inValid = 1'b0;
        tick();
        check("b2b.jal.valid", {31'd0, outValid}, 32'd1);
        check("b2b.jal",       instr, 32'h008000EF);
        check("b2b.jal.err",   {31'd0, rangeErr}, 32'd0);
        tick();
        check("b2b.empty", {31'd0, outValid}, 32'd0);

        // Range errors: word still emitted with truncated fields
        set_in(3'b000, 32'h00000800, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
        one_word("errI", 32'h80000013, 1'b1);
        set_in(3'b010, 32'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
        one_word("errB", 32'h00000163, 1'b1);
        set_in(3'b011, 32'h12345001, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
        one_word("errU", 32'h12345037, 1'b1);
        check("errCount3", {24'd0, errCount}, 32'd3);

        // In-range boundary / other types
        set_in(3'b000, 32'hFFFFF800, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
        one_word("okI.min", 32'h80000013, 1'b0);
        set_in(3'b010, 32'hFFFFFFFC, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0);
        one_word("beq.m4", 32'hFE208EE3, 1'b0);
        set_in(3'b101, 32'hFFFFFFFF, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0);
        one_word("add.R", 32'h002081B3, 1'b0);
        check("errCount.hold3", {24'd0, errCount}, 32'd3);

        // Backpressure: outReady low for 5 cycles, inValid high throughout
        outReady = 1'b0;
        accepted = 0;
        inValid  = 1'b1;
        set_in(3'b000, 32'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        for (int c = 0; c < 5; c++) begin
            acc = inReady;
            tick();
            if (acc) begin
                accepted++;
                set_in(3'b000, 32'(accepted + 1), 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
            end
            if (c >= 1) check("bp.stable", instr, 32'h00100093);
        end
        check("bp.accepted", 32'(accepted), 32'd2);
        check("bp.inReady",  {31'd0, inReady}, 32'd0);
        inValid  = 1'b0;
        outReady = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (outValid) drained.push_back(instr);
            tick();
        end
        check("bp.count", 32'(drained.size()), 32'd2);
        if (drained.size() == 2) begin
            check("bp.w0", drained[0], 32'h00100093);
            check("bp.w1", drained[1], 32'h00200093);
        end

        // Reset with both stages full
        outReady = 1'b0;
        set_in(3'b000, 32'h00000800, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
        inValid = 1'b1;
        tick();
        tick();
        inValid = 1'b0;
        check("mid.full",     {31'd0, outValid}, 32'd1);
        check("mid.fullRdy",  {31'd0, inReady}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid.outValid", {31'd0, outValid}, 32'd0);
        check("mid.errCount", {24'd0, errCount}, 32'd0);
        check("mid.inReady",  {31'd0, inReady}, 32'd1);
        outReady = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (outValid) seen++;
        end
        check("mid.noStale",  32'(seen), 32'd0);
        check("mid.errHold0", {24'd0, errCount}, 32'd0);

        // Saturation: stream 260 error words at full rate
        set_in(3'b011, 32'h00000001, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
        inValid = 1'b1;
        for (int c = 0; c < 100; c++) tick();
        check("sat.mid", {24'd0, errCount}, 32'd98);
        for (int c = 0; c < 160; c++) tick();
        inValid = 1'b0;
        tick();
        tick();
        check("sat.full", {24'd0, errCount}, 32'd255);
        tick();
        tick();
        check("sat.hold", {24'd0, errCount}, 32'd255);
        check("sat.idle", {31'd0, outValid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extender: packs register fields plus a 32-bit immediate value into a 32-bit RV32I instruction word.
- Places immediate bits per I/S/B/U/J type.
- Range-checks the immediate and flags values that would not round-trip through the extender.
- Two-register valid/ready pipeline with an error counter.
- Used by the instruction-memory loader and the self-check bench, to build instruction words.

Parameters:
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- inValid  input  1  request present.
- inReady  output  1  request accepted this cycle when inValid&&inReady.
- immSrc  input  3  000 I, 001 S, 010 B, 011 U, 100 J, 101-111 R (no immediate).
- immValue  input  32  signed byte-offset / immediate to encode.
- opcode  input  7  instr[6:0].
- rd  input  5  destination register.
- rs1  input  5  source 1.
- rs2  input  5  source 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field, used for R only.
- outValid  output  1  encoded word present.
- outReady  input  1  consumer accepts when outValid&&outReady.
- instr  output  32  encoded instruction.
- rangeErr  output  1  immediate out of range for this type; travels with instr.
- errCount  output  ERR_CNT_W  number of rangeErr words delivered, saturating.

Behaviour:
- Reset (clk edge with rst=1): stage A and stage B valid = 0; outValid=0, instr=0, rangeErr=0, errCount=0. rst dominates any handshake in the same cycle; in-flight words are discarded.
- Stage A register captures all inputs on inValid&&inReady.
- Stage B computes the encoding from stage A combinationally and registers instr/rangeErr into the output register.
- Latency is 2 cycles from input accept to outValid without stalls. Throughput is 1 word/cycle.
- Flow control:
  - advB = !outValidB || outReady.
  - advA = !validA || advB.
  - inReady = advA, a pure function of registered state and outReady.
  - Stage B holds instr/rangeErr stable while outValid && !outReady.
- Encoding (f3 = funct3):
  - All types: instr[6:0] = opcode.
  - I: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=f3, [11:7]=rd.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=f3, [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=f3, [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12], [11:7]=rd.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd.
  - R (101-111): [31:25]=funct7, [24:20]=rs2, [19:15]=rs1, [14:12]=f3, [11:7]=rd.
- Range rules (rangeErr=1 if violated):
  - I and S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - R: never an error.
- On rangeErr the word is still emitted with truncated bits per the encoding table; no dropping.
- errCount increments by 1 on each outValid&&outReady&&rangeErr. It holds at all-ones.
- Simultaneous input accept and output drain in one cycle is legal: both stages advance and no bubble is inserted.

Test Plan:
- I, addi x1,x0,5: immSrc=000, opcode=0x13, rd=1, rs1=0, f3=0, imm=5, outReady=1.
  - Required: instr=0x00500093, rangeErr=0, outValid exactly 2 cycles after accept.
- S/U/J, back-to-back with one word per cycle:
  - sw: imm=8, rs2=2, rs1=0, f3=2, opcode=0x23 → 0x00202423.
  - lui: imm=0x12345000, rd=5, opcode=0x37 → 0x123452B7.
  - jal: imm=8, rd=1, opcode=0x6F → 0x008000EF.
  - Required: three consecutive outValid cycles, in order.
- Range errors:
  - I imm=0x800 → rangeErr=1, instr[31:20]=0x800.
  - B imm=3 → rangeErr=1.
  - U imm=0x12345001 → rangeErr=1.
  - Required: errCount=3 after the three are delivered.
- Backpressure: outReady=0 for 5 cycles while inValid=1 continuously.
  - Required: exactly 2 words accepted, then inReady=0.
  - Required: instr stable during the stall.
  - Required: on release, the words drain in order with no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle with both stages full.
  - Required: next cycle outValid=0, errCount=0, inReady=1.
  - Required: no stale word appears afterward.
- errCount saturation: deliver 260 error words.
  - Required: errCount=255 and holds.
